// File: rtl/reg_write_sequencer_pkg.sv
// Shared types for the register write sequencer: port identifiers, the last-operation
// encoding used by the read/write interleave, and the default datapath width.
package reg_seq_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_e;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT1) ? PORT2 : PORT1;
    endfunction

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Request/strobe bundle between a request source (master) and reg_write_sequencer (slave).
interface reg_write_sequencer_if
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              wr1_valid;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ready;
    logic              wr2_valid;
    logic [DATA_W-1:0] wr2_data;
    logic              wr2_ready;
    logic              rd_req;
    logic              rd_busy;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wsel;
    logic              reg_re;
    logic              alt_stall;

    modport master (
        output wr1_valid, wr1_data, wr2_valid, wr2_data, rd_req,
        input  wr1_ready, wr2_ready, rd_busy, reg_we, reg_wdata, reg_wsel, reg_re, alt_stall
    );

    modport slave (
        input  wr1_valid, wr1_data, wr2_valid, wr2_data, rd_req,
        output wr1_ready, wr2_ready, rd_busy, reg_we, reg_wdata, reg_wsel, reg_re, alt_stall
    );

endinterface

// File: rtl/reg_write_sequencer_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; one per write port.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the emptied pointers make stale
    // entries unreachable, and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_write_sequencer.sv
// Buffers two write ports and one read port and issues at most one register
// operation per cycle, alternating write ports strictly and interleaving reads.
module reg_write_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst,
    reg_write_sequencer_if.slave bus
);

    logic              full1, empty1, full2, empty2;
    logic              push1, push2, pop1, pop2;
    logic [DATA_W-1:0] dout1, dout2;

    port_e turn, turn_next;
    op_e   last_op, last_op_next;
    logic  rd_pending, rd_pending_next;
    logic  turn_empty, other_empty, w_ok;
    logic  do_read, do_write;

    logic              reg_we_q, reg_re_q, reg_wsel_q;
    logic [DATA_W-1:0] reg_wdata_q;

    assign bus.wr1_ready = !full1 && !rst;
    assign bus.wr2_ready = !full2 && !rst;
    assign push1 = bus.wr1_valid && bus.wr1_ready;
    assign push2 = bus.wr2_valid && bus.wr2_ready;
    assign pop1  = do_write && (turn == PORT1);
    assign pop2  = do_write && (turn == PORT2);

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (pop1),
        .din   (bus.wr1_data),
        .dout  (dout1),
        .full  (full1),
        .empty (empty1)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push2),
        .pop   (pop2),
        .din   (bus.wr2_data),
        .dout  (dout2),
        .full  (full2),
        .empty (empty2)
    );

    assign turn_empty  = (turn == PORT1) ? empty1 : empty2;
    assign other_empty = (turn == PORT1) ? empty2 : empty1;
    assign w_ok        = !turn_empty;

    // The non-turn port is never served early; it only waits.
    assign bus.alt_stall = !other_empty && turn_empty;
    assign bus.rd_busy   = rd_pending;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        do_read         = 1'b0;
        do_write        = 1'b0;
        turn_next       = turn;
        last_op_next    = OP_IDLE;
        rd_pending_next = rd_pending;

        if (rd_pending && (!w_ok || last_op != OP_READ)) begin
            do_read         = 1'b1;
            last_op_next    = OP_READ;
            rd_pending_next = 1'b0;
        end else if (w_ok) begin
            do_write     = 1'b1;
            last_op_next = OP_WRITE;
            turn_next    = other_port(turn);
        end

        // A request on the issuing edge re-arms the pending flag.
        if (bus.rd_req) rd_pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            turn        <= PORT1;
            last_op     <= OP_IDLE;
            rd_pending  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_wdata_q <= '0;
            reg_wsel_q  <= 1'b0;
        end else begin
            turn       <= turn_next;
            last_op    <= last_op_next;
            rd_pending <= rd_pending_next;
            reg_we_q   <= do_write;
            reg_re_q   <= do_read;
            if (do_write) begin
                reg_wdata_q <= (turn == PORT1) ? dout1 : dout2;
                reg_wsel_q  <= (turn == PORT2);
            end
        end
    end

    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wsel  = reg_wsel_q;

endmodule
